header_fec_codec: RTL and testbench

HEADER_FEC_CODEC -- requirements
Module: header_fec_codec

---
 rtl/header_fec_codec.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_header_fec_codec.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/header_fec_codec.sv
// ---------------------------------------------------------------------------
// header_fec_codec
//
// Packet-header encoder/decoder with HEC generation/check, data whitening and
// 1/FEC_REP repetition coding. A 10-bit header {seqn,arqn,flow,type,lt_addr}
// is sent LSB first, followed by its 8-bit HEC MSB first. Each of the 18
// resulting info bits is whitened and repeated FEC_REP times on txbit. The
// receive path majority-votes each group of FEC_REP samples, dewhitens the
// result, and rebuilds the header and HEC remainder. It also keeps per-LT_ADDR
// ARQN/FLOW state. All bit-level activity is paced by the p_1us strobe.
//
// Parameters
//   NLT      number of LT_ADDR slots tracked (2..8)
//   FEC_REP  repetition factor (odd, 1..5)
//   ERRW     width of the FEC disagreement counter
//
// Ports
//   clk_6M, rstz              clock, asynchronous active-low reset
//   p_1us                     bit strobe
//   tx_start_p, rx_start_p    start encode / decode (taken with p_1us in IDLE)
//   abort                     return to IDLE immediately, beats any start
//   tx_lt_addr..tx_seqn       header fields to transmit, sampled at start
//   uap, clk27_1, whiten_en   HEC seed, whitening seed CLK[6:1], enable
//   my_lt_addr                own address for lt_match
//   rxbit                     received bit, sampled on p_1us
//   txbit                     encoded header bit, 0 outside TX states
//   busy                      1 whenever not IDLE
//   hdr_done_p                one-cycle completion pulse (TX or RX)
//   hec_good, lt_match        RX check results
//   dec_*                     decoded header fields
//   arqn_q, flow_q            per-LT ARQN / FLOW state
//   flow_start_p              per-LT pulse on a FLOW 0->1 transition
//   fec_err_cnt               saturating count of non-unanimous vote groups
// ---------------------------------------------------------------------------
module header_fec_codec #(
   parameter int NLT     = 8,
   parameter int FEC_REP = 3,
   parameter int ERRW    = 8
) (
   input  logic            clk_6M,
   input  logic            rstz,
   input  logic            p_1us,
   input  logic            tx_start_p,
   input  logic            rx_start_p,
   input  logic            abort,
   input  logic [2:0]      tx_lt_addr,
   input  logic [3:0]      tx_type,
   input  logic            tx_flow,
   input  logic            tx_arqn,
   input  logic            tx_seqn,
   input  logic [7:0]      uap,
   input  logic [5:0]      clk27_1,
   input  logic            whiten_en,
   input  logic [2:0]      my_lt_addr,
   input  logic            rxbit,
   output logic            txbit,
   output logic            busy,
   output logic            hdr_done_p,
   output logic            hec_good,
   output logic            lt_match,
   output logic [2:0]      dec_lt_addr,
   output logic [3:0]      dec_type,
   output logic            dec_flow,
   output logic            dec_arqn,
   output logic            dec_seqn,
   output logic [NLT-1:0]  arqn_q,
   output logic [NLT-1:0]  flow_q,
   output logic [NLT-1:0]  flow_start_p,
   output logic [ERRW-1:0] fec_err_cnt
);

   // HEC generator x^8+x^7+x^5+x^2+x+1, x^8 term implied by the shift.
   localparam logic [7:0] HEC_POLY = 8'hA7;
   localparam logic [2:0] REP_LAST = 3'(FEC_REP - 1);
   localparam logic [2:0] REP_HALF = 3'(FEC_REP / 2);
   localparam logic [2:0] REP_ALL  = 3'(FEC_REP);
   localparam logic [4:0] HDR_LAST = 5'd9;    // index of the last header bit
   localparam logic [4:0] INFO_LAST = 5'd17;  // index of the last HEC bit
   localparam logic [4:0] INFO_END = 5'd18;   // all info bits already sent

   typedef enum logic [2:0] {
      IDLE,
      TXHDR,
      TXHEC,
      RXHDR,
      RXHEC,
      CHECK
   } state_t;

   state_t      state, state_nxt;

   logic [9:0]  hdr_sr;     // TX: header shifted out LSB first; RX: bits shifted in
   logic [7:0]  hec_sr;     // HEC LFSR; holds the HEC to send or the RX remainder
   logic [6:0]  wht_sr;     // whitening LFSR
   logic        wht_en_q;
   logic [4:0]  bit_cnt;    // info bit index 0..18
   logic [2:0]  rep_cnt;    // repetition index within the current info bit
   logic [2:0]  ones_cnt;   // ones seen so far in the current RX vote group
   logic [2:0]  tx_lt_q;

   // FSM strobes for the datapath
   logic        ld_tx, ld_rx, tx_step, tx_done, rx_step, chk_fire;

   // Galois step of the HEC LFSR with one input bit.
   function automatic logic [7:0] hec_step(input logic [7:0] h, input logic d);
      return {h[6:0], 1'b0} ^ ({8{d ^ h[7]}} & HEC_POLY);
   endfunction

   // Galois step of the whitening LFSR x^7+x^4+1; output bit is w[6].
   function automatic logic [6:0] wht_step(input logic [6:0] w);
      return {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
   endfunction

   logic       wht_bit;
   logic       rep_last;
   logic       tx_info;
   logic [2:0] ones_tot;
   logic       rx_vote;
   logic       rx_unan;
   logic       rx_bit;
   logic       crc_ok;
   logic [2:0] hdr_lt;

   assign wht_bit  = wht_en_q & wht_sr[6];
   assign rep_last = (rep_cnt == REP_LAST);
   // Header bits come from the shift register; HEC bits leave MSB first.
   assign tx_info  = (state == TXHDR) ? hdr_sr[0] : hec_sr[7];
   assign ones_tot = ones_cnt + {2'b00, rxbit};
   assign rx_vote  = (ones_tot > REP_HALF);
   assign rx_unan  = (ones_tot == 3'd0) || (ones_tot == REP_ALL);
   assign rx_bit   = rx_vote ^ wht_bit;
   // Running the received HEC through the same LFSR leaves zero when intact.
   assign crc_ok   = (hec_sr == 8'd0);
   assign hdr_lt   = hdr_sr[2:0];

   assign busy     = (state != IDLE);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         state <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and datapath strobes
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_nxt = state;
      ld_tx     = 1'b0;
      ld_rx     = 1'b0;
      tx_step   = 1'b0;
      tx_done   = 1'b0;
      rx_step   = 1'b0;
      chk_fire  = 1'b0;

      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (p_1us && tx_start_p) begin
                  state_nxt = TXHDR;
                  ld_tx     = 1'b1;
               end else if (p_1us && rx_start_p) begin
                  state_nxt = RXHDR;
                  ld_rx     = 1'b1;
               end
            end
            TXHDR, TXHEC: begin
               if (p_1us) begin
                  // One extra strobe after the last repetition lets the final
                  // bit occupy a full bit period before completion.
                  if (bit_cnt == INFO_END) begin
                     tx_done   = 1'b1;
                     state_nxt = IDLE;
                  end else begin
                     tx_step = 1'b1;
                     if (rep_last && (bit_cnt == HDR_LAST)) state_nxt = TXHEC;
                  end
               end
            end
            RXHDR, RXHEC: begin
               if (p_1us) begin
                  rx_step = 1'b1;
                  if (rep_last && (bit_cnt == HDR_LAST))  state_nxt = RXHEC;
                  if (rep_last && (bit_cnt == INFO_LAST)) state_nxt = CHECK;
               end
            end
            CHECK: begin
               if (p_1us) begin
                  chk_fire  = 1'b1;
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Datapath, status and per-LT state
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         txbit        <= 1'b0;
         hdr_done_p   <= 1'b0;
         hec_good     <= 1'b0;
         lt_match     <= 1'b0;
         dec_lt_addr  <= 3'd0;
         dec_type     <= 4'd0;
         dec_flow     <= 1'b0;
         dec_arqn     <= 1'b0;
         dec_seqn     <= 1'b0;
         // NOTE: the per-LT arrays are link state that other logic reads right
         // after reset, so they are flops with a defined reset value rather
         // than an unreset memory.
         arqn_q       <= '0;
         flow_q       <= '1;
         flow_start_p <= '0;
         fec_err_cnt  <= '0;
         hdr_sr       <= 10'd0;
         hec_sr       <= 8'd0;
         wht_sr       <= 7'd0;
         wht_en_q     <= 1'b0;
         bit_cnt      <= 5'd0;
         rep_cnt      <= 3'd0;
         ones_cnt     <= 3'd0;
         tx_lt_q      <= 3'd0;
      end else begin
         hdr_done_p   <= tx_done | chk_fire;
         flow_start_p <= '0;

         // txbit is only non-zero while a TX state is (or stays) active.
         if (tx_step) begin
            txbit <= tx_info ^ wht_bit;
         end else if (!(state_nxt inside {TXHDR, TXHEC})) begin
            txbit <= 1'b0;
         end

         if (ld_tx) begin
            hdr_sr   <= {tx_seqn, tx_arqn, tx_flow, tx_type, tx_lt_addr};
            hec_sr   <= uap;
            wht_sr   <= {1'b1, clk27_1};
            wht_en_q <= whiten_en;
            bit_cnt  <= 5'd0;
            rep_cnt  <= 3'd0;
            tx_lt_q  <= tx_lt_addr;
         end

         if (ld_rx) begin
            hdr_sr      <= 10'd0;
            hec_sr      <= uap;
            wht_sr      <= {1'b1, clk27_1};
            wht_en_q    <= whiten_en;
            bit_cnt     <= 5'd0;
            rep_cnt     <= 3'd0;
            ones_cnt    <= 3'd0;
            fec_err_cnt <= '0;
         end

         if (tx_step) begin
            if (rep_last) begin
               rep_cnt <= 3'd0;
               bit_cnt <= bit_cnt + 5'd1;
               wht_sr  <= wht_step(wht_sr);
               if (state == TXHDR) begin
                  hec_sr <= hec_step(hec_sr, hdr_sr[0]);
                  hdr_sr <= {1'b0, hdr_sr[9:1]};
               end else begin
                  hec_sr <= {hec_sr[6:0], 1'b0};
               end
            end else begin
               rep_cnt <= rep_cnt + 3'd1;
            end
         end

         if (rx_step) begin
            if (rep_last) begin
               rep_cnt  <= 3'd0;
               ones_cnt <= 3'd0;
               bit_cnt  <= bit_cnt + 5'd1;
               wht_sr   <= wht_step(wht_sr);
               hec_sr   <= hec_step(hec_sr, rx_bit);
               if (state == RXHDR) hdr_sr <= {rx_bit, hdr_sr[9:1]};
               if (!rx_unan && (fec_err_cnt != '1)) fec_err_cnt <= fec_err_cnt + 1'b1;
            end else begin
               rep_cnt  <= rep_cnt + 3'd1;
               ones_cnt <= ones_tot;
            end
         end

         if (chk_fire) begin
            dec_lt_addr <= hdr_sr[2:0];
            dec_type    <= hdr_sr[6:3];
            dec_flow    <= hdr_sr[7];
            dec_arqn    <= hdr_sr[8];
            dec_seqn    <= hdr_sr[9];
            hec_good    <= crc_ok;
            lt_match    <= crc_ok && (hdr_lt == my_lt_addr);
            // Addresses at or above NLT match no slot and update nothing.
            for (int i = 0; i < NLT; i++) begin
               if (crc_ok && (hdr_lt == i[2:0])) begin
                  arqn_q[i]       <= hdr_sr[8];
                  flow_q[i]       <= hdr_sr[7];
                  flow_start_p[i] <= hdr_sr[7] & ~flow_q[i];
               end
            end
         end

         // A transmitted header leaves that link NAKed until a valid reply.
         if (tx_done) begin
            for (int i = 0; i < NLT; i++) begin
               if (tx_lt_q == i[2:0]) arqn_q[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_header_fec_codec.sv
module tb_header_fec_codec;

   localparam int NLT     = 8;
   localparam int FEC_REP = 3;
   localparam int ERRW    = 8;

   logic            clk_6M = 1'b0;
   logic            rstz;
   logic            p_1us;
   logic            tx_start_p, rx_start_p, abort;
   logic [2:0]      tx_lt_addr;
   logic [3:0]      tx_type;
   logic            tx_flow, tx_arqn, tx_seqn;
   logic [7:0]      uap;
   logic [5:0]      clk27_1;
   logic            whiten_en;
   logic [2:0]      my_lt_addr;
   logic            rxbit;
   logic            txbit, busy, hdr_done_p, hec_good, lt_match;
   logic [2:0]      dec_lt_addr;
   logic [3:0]      dec_type;
   logic            dec_flow, dec_arqn, dec_seqn;
   logic [NLT-1:0]  arqn_q, flow_q, flow_start_p;
   logic [ERRW-1:0] fec_err_cnt;

   int vectors     = 0;
   int miscompares = 0;

   // Hand-computed info bit streams in transmission order for header
   // lt=3 type=0001 flow=1 arqn=0 seqn=1 (word 0x28B), uap=0x47 -> HEC 0x43.
   logic [0:17] exp_plain;
   // Same bits XORed with whitening from seed {1,0x2A}: 110011000001101101.
   logic [0:17] exp_white;
   logic [0:53] s_white, s_b, s_tmp;
   logic [2:0]  fl;

   header_fec_codec #(.NLT(NLT), .FEC_REP(FEC_REP), .ERRW(ERRW)) dut (
      .clk_6M(clk_6M), .rstz(rstz), .p_1us(p_1us),
      .tx_start_p(tx_start_p), .rx_start_p(rx_start_p), .abort(abort),
      .tx_lt_addr(tx_lt_addr), .tx_type(tx_type), .tx_flow(tx_flow),
      .tx_arqn(tx_arqn), .tx_seqn(tx_seqn), .uap(uap), .clk27_1(clk27_1),
      .whiten_en(whiten_en), .my_lt_addr(my_lt_addr), .rxbit(rxbit),
      .txbit(txbit), .busy(busy), .hdr_done_p(hdr_done_p), .hec_good(hec_good),
      .lt_match(lt_match), .dec_lt_addr(dec_lt_addr), .dec_type(dec_type),
      .dec_flow(dec_flow), .dec_arqn(dec_arqn), .dec_seqn(dec_seqn),
      .arqn_q(arqn_q), .flow_q(flow_q), .flow_start_p(flow_start_p),
      .fec_err_cnt(fec_err_cnt)
   );

   always #5 clk_6M = ~clk_6M;

   // Bit strobe: one clock high out of every four.
   initial begin
      p_1us = 1'b0;
      forever begin
         repeat (3) @(negedge clk_6M);
         p_1us = 1'b1;
         @(negedge clk_6M);
         p_1us = 1'b0;
      end
   end

   function automatic logic [0:53] triple(input logic [0:17] b);
      logic [0:53] t;
      for (int i = 0; i < 18; i++)
         for (int r = 0; r < 3; r++) t[3*i+r] = b[i];
      return t;
   endfunction

   function automatic logic [9:0] dec_word();
      return {dec_seqn, dec_arqn, dec_flow, dec_type, dec_lt_addr};
   endfunction

   // Return 1 time unit after the next clock edge that carries p_1us.
   task automatic wait_strobe();
      do @(posedge clk_6M); while (p_1us !== 1'b1);
      #1;
   endtask

   task automatic set_hdr(input logic [2:0] lt, input logic [3:0] ty,
                          input logic fl_i, input logic ar, input logic sq);
      tx_lt_addr = lt; tx_type = ty; tx_flow = fl_i; tx_arqn = ar; tx_seqn = sq;
   endtask

   task automatic start_tx(input logic also_rx);
      @(negedge clk_6M);
      tx_start_p = 1'b1;
      rx_start_p = also_rx;
      wait_strobe();
      tx_start_p = 1'b0;
      rx_start_p = 1'b0;
   endtask

   // Full TX: captures the 54 bits, a stray rx_start_p mid-packet, and returns
   // {busy after start, hdr_done_p at final strobe, busy after completion}.
   task automatic do_tx(input logic also_rx, output logic [0:53] s, output logic [2:0] f);
      start_tx(also_rx);
      f[2] = busy;
      for (int k = 0; k < 54; k++) begin
         if (k == 20) begin
            @(negedge clk_6M);
            rx_start_p = 1'b1;
         end
         wait_strobe();
         rx_start_p = 1'b0;
         s[k] = txbit;
      end
      wait_strobe();
      f[1] = hdr_done_p;
      f[0] = busy;
   endtask

   task automatic start_rx();
      @(negedge clk_6M);
      rx_start_p = 1'b1;
      wait_strobe();
      rx_start_p = 1'b0;
   endtask

   task automatic feed_rx(input logic [0:53] s, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk_6M);
         rxbit = s[k];
         wait_strobe();
      end
   endtask

   // -----------------------------------------------------------------------
   task automatic test_reset();
      rstz = 1'b0;
      repeat (3) @(posedge clk_6M);
      #1;
      vectors++; if (txbit !== 1'b0) begin miscompares++; $display("FAIL rst_txbit: got %b want 0", txbit); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
      vectors++; if ({hdr_done_p, hec_good, lt_match} !== 3'b000) begin miscompares++; $display("FAIL rst_status: got %b want 000", {hdr_done_p, hec_good, lt_match}); end
      vectors++; if (dec_word() !== 10'h000) begin miscompares++; $display("FAIL rst_dec: got %h want 000", dec_word()); end
      vectors++; if (fec_err_cnt !== 8'h00) begin miscompares++; $display("FAIL rst_fec: got %h want 00", fec_err_cnt); end
      vectors++; if (arqn_q !== 8'h00) begin miscompares++; $display("FAIL rst_arqn: got %h want 00", arqn_q); end
      vectors++; if (flow_q !== 8'hFF) begin miscompares++; $display("FAIL rst_flow: got %h want ff", flow_q); end
      vectors++; if (flow_start_p !== 8'h00) begin miscompares++; $display("FAIL rst_flow_start: got %h want 00", flow_start_p); end
      @(negedge clk_6M);
      rstz = 1'b1;
   endtask

   // TX of the reference header without whitening; both starts asserted.
   task automatic test_tx_plain();
      logic [0:53] s;
      set_hdr(3'd3, 4'b0001, 1'b1, 1'b0, 1'b1);
      whiten_en = 1'b0;
      do_tx(1'b1, s, fl);
      vectors++; if (fl[2] !== 1'b1) begin miscompares++; $display("FAIL tx_busy: got %b want 1", fl[2]); end
      vectors++; if (s !== triple(exp_plain)) begin miscompares++; $display("FAIL tx_plain_bits: got %h want %h", s, triple(exp_plain)); end
      vectors++; if (fl[1] !== 1'b1) begin miscompares++; $display("FAIL tx_done: got %b want 1", fl[1]); end
      vectors++; if (fl[0] !== 1'b0) begin miscompares++; $display("FAIL tx_busy_end: got %b want 0", fl[0]); end
      vectors++; if (txbit !== 1'b0) begin miscompares++; $display("FAIL tx_idle_txbit: got %b want 0", txbit); end
      vectors++; if (hec_good !== 1'b0) begin miscompares++; $display("FAIL tx_hec_good: got %b want 0", hec_good); end
      @(posedge clk_6M); #1;
      vectors++; if (hdr_done_p !== 1'b0) begin miscompares++; $display("FAIL tx_done_width: got %b want 0", hdr_done_p); end
   endtask

   task automatic test_loopback();
      whiten_en  = 1'b1;
      my_lt_addr = 3'd3;
      do_tx(1'b0, s_white, fl);
      vectors++; if (s_white !== triple(exp_white)) begin miscompares++; $display("FAIL lb_white_bits: got %h want %h", s_white, triple(exp_white)); end
      start_rx();
      feed_rx(s_white, 54);
      wait_strobe();
      vectors++; if (hdr_done_p !== 1'b1) begin miscompares++; $display("FAIL lb_done: got %b want 1", hdr_done_p); end
      vectors++; if (hec_good !== 1'b1) begin miscompares++; $display("FAIL lb_hec_good: got %b want 1", hec_good); end
      vectors++; if (dec_word() !== 10'h28B) begin miscompares++; $display("FAIL lb_fields: got %h want 28b", dec_word()); end
      vectors++; if (lt_match !== 1'b1) begin miscompares++; $display("FAIL lb_lt_match: got %b want 1", lt_match); end
      vectors++; if (fec_err_cnt !== 8'd0) begin miscompares++; $display("FAIL lb_fec: got %0d want 0", fec_err_cnt); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL lb_busy: got %b want 0", busy); end
   endtask

   task automatic test_fec_single();
      s_tmp = s_white;
      s_tmp[0] = ~s_tmp[0]; s_tmp[10] = ~s_tmp[10]; s_tmp[23] = ~s_tmp[23];
      s_tmp[36] = ~s_tmp[36]; s_tmp[53] = ~s_tmp[53];
      start_rx();
      feed_rx(s_tmp, 54);
      wait_strobe();
      vectors++; if (hec_good !== 1'b1) begin miscompares++; $display("FAIL fec1_hec_good: got %b want 1", hec_good); end
      vectors++; if (dec_word() !== 10'h28B) begin miscompares++; $display("FAIL fec1_fields: got %h want 28b", dec_word()); end
      vectors++; if (fec_err_cnt !== 8'd5) begin miscompares++; $display("FAIL fec1_cnt: got %0d want 5", fec_err_cnt); end
   endtask

   // Two flips in the arqn group corrupt arqn to 1; the bad HEC must block it.
   task automatic test_fec_double();
      s_tmp = s_white;
      s_tmp[24] = ~s_tmp[24]; s_tmp[26] = ~s_tmp[26];
      start_rx();
      feed_rx(s_tmp, 54);
      wait_strobe();
      vectors++; if (hdr_done_p !== 1'b1) begin miscompares++; $display("FAIL fec2_done: got %b want 1", hdr_done_p); end
      vectors++; if (hec_good !== 1'b0) begin miscompares++; $display("FAIL fec2_hec_good: got %b want 0", hec_good); end
      vectors++; if (lt_match !== 1'b0) begin miscompares++; $display("FAIL fec2_lt_match: got %b want 0", lt_match); end
      vectors++; if (fec_err_cnt !== 8'd1) begin miscompares++; $display("FAIL fec2_cnt: got %0d want 1", fec_err_cnt); end
      vectors++; if (arqn_q !== 8'h00) begin miscompares++; $display("FAIL fec2_arqn: got %h want 00", arqn_q); end
      vectors++; if (flow_q !== 8'hFF) begin miscompares++; $display("FAIL fec2_flow: got %h want ff", flow_q); end
   endtask

   task automatic test_flow_start();
      // Header A: lt=2 type=0100 flow=0 arqn=1 seqn=0 (word 0x122).
      set_hdr(3'd2, 4'b0100, 1'b0, 1'b1, 1'b0);
      do_tx(1'b0, s_tmp, fl);
      start_rx();
      feed_rx(s_tmp, 54);
      wait_strobe();
      vectors++; if (dec_word() !== 10'h122) begin miscompares++; $display("FAIL fs_a_fields: got %h want 122", dec_word()); end
      vectors++; if ({hec_good, lt_match} !== 2'b10) begin miscompares++; $display("FAIL fs_a_match: got %b want 10", {hec_good, lt_match}); end
      vectors++; if (arqn_q !== 8'h04) begin miscompares++; $display("FAIL fs_a_arqn: got %h want 04", arqn_q); end
      vectors++; if (flow_q !== 8'hFB) begin miscompares++; $display("FAIL fs_a_flow: got %h want fb", flow_q); end
      vectors++; if (flow_start_p !== 8'h00) begin miscompares++; $display("FAIL fs_a_pulse: got %h want 00", flow_start_p); end
      // Header B: lt=2 type=0011 flow=1 arqn=1 seqn=1 (word 0x39A).
      set_hdr(3'd2, 4'b0011, 1'b1, 1'b1, 1'b1);
      do_tx(1'b0, s_b, fl);
      vectors++; if (arqn_q !== 8'h00) begin miscompares++; $display("FAIL fs_tx_clear: got %h want 00", arqn_q); end
      start_rx();
      feed_rx(s_b, 54);
      wait_strobe();
      vectors++; if (dec_word() !== 10'h39A) begin miscompares++; $display("FAIL fs_b_fields: got %h want 39a", dec_word()); end
      vectors++; if (arqn_q !== 8'h04) begin miscompares++; $display("FAIL fs_b_arqn: got %h want 04", arqn_q); end
      vectors++; if (flow_q !== 8'hFF) begin miscompares++; $display("FAIL fs_b_flow: got %h want ff", flow_q); end
      vectors++; if (flow_start_p !== 8'h04) begin miscompares++; $display("FAIL fs_b_pulse: got %h want 04", flow_start_p); end
      @(posedge clk_6M); #1;
      vectors++; if (flow_start_p !== 8'h00) begin miscompares++; $display("FAIL fs_b_pulse_end: got %h want 00", flow_start_p); end
   endtask

   task automatic test_abort_restart();
      s_tmp = s_b;
      s_tmp[1] = ~s_tmp[1];
      start_rx();
      feed_rx(s_tmp, 20);
      vectors++; if ({busy, fec_err_cnt} !== {1'b1, 8'd1}) begin miscompares++; $display("FAIL ab_mid: got busy=%b cnt=%0d want busy=1 cnt=1", busy, fec_err_cnt); end
      @(negedge clk_6M);
      abort = 1'b1;
      @(posedge clk_6M); #1;
      abort = 1'b0;
      vectors++; if ({busy, hdr_done_p} !== 2'b00) begin miscompares++; $display("FAIL ab_idle: got %b want 00", {busy, hdr_done_p}); end
      vectors++; if (dec_word() !== 10'h39A) begin miscompares++; $display("FAIL ab_fields: got %h want 39a", dec_word()); end
      vectors++; if ({arqn_q, flow_q} !== {8'h04, 8'hFF}) begin miscompares++; $display("FAIL ab_arrays: got %h want 04ff", {arqn_q, flow_q}); end
      start_rx();
      vectors++; if ({busy, fec_err_cnt} !== {1'b1, 8'd0}) begin miscompares++; $display("FAIL ab_restart: got busy=%b cnt=%0d want busy=1 cnt=0", busy, fec_err_cnt); end
      feed_rx(s_b, 54);
      wait_strobe();
      vectors++; if ({hdr_done_p, hec_good} !== 2'b11) begin miscompares++; $display("FAIL ab_rx_ok: got %b want 11", {hdr_done_p, hec_good}); end
      // abort beats a simultaneous start
      @(negedge clk_6M);
      tx_start_p = 1'b1;
      abort      = 1'b1;
      wait_strobe();
      tx_start_p = 1'b0;
      abort      = 1'b0;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ab_prio: got %b want 0", busy); end
   endtask

   task automatic test_reset_mid_tx();
      logic done_seen;
      set_hdr(3'd3, 4'b0001, 1'b1, 1'b0, 1'b1);
      whiten_en = 1'b0;
      start_tx(1'b0);
      repeat (2) wait_strobe();
      vectors++; if (txbit !== 1'b1) begin miscompares++; $display("FAIL rm_txbit_pre: got %b want 1", txbit); end
      #2 rstz = 1'b0;
      #1;
      vectors++; if ({txbit, busy} !== 2'b00) begin miscompares++; $display("FAIL rm_async: got %b want 00", {txbit, busy}); end
      vectors++; if ({arqn_q, flow_q} !== {8'h00, 8'hFF}) begin miscompares++; $display("FAIL rm_arrays: got %h want 00ff", {arqn_q, flow_q}); end
      @(negedge clk_6M);
      rstz = 1'b1;
      done_seen = 1'b0;
      for (int k = 0; k < 60; k++) begin
         wait_strobe();
         done_seen = done_seen | hdr_done_p | busy;
      end
      vectors++; if (done_seen !== 1'b0) begin miscompares++; $display("FAIL rm_no_done: got %b want 0", done_seen); end
   endtask

   initial begin
      rstz = 1'b0; tx_start_p = 1'b0; rx_start_p = 1'b0; abort = 1'b0;
      tx_lt_addr = 3'd0; tx_type = 4'd0; tx_flow = 1'b0; tx_arqn = 1'b0; tx_seqn = 1'b0;
      uap = 8'h47; clk27_1 = 6'h2A; whiten_en = 1'b0; my_lt_addr = 3'd3; rxbit = 1'b0;
      exp_plain = 18'b110100010101000011;
      exp_white = 18'b000111010100101110;

      test_reset();
      test_tx_plain();
      test_loopback();
      test_fec_single();
      test_fec_double();
      test_flow_start();
      test_abort_restart();
      test_reset_mid_tx();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
